// File: rtl/ysyx_25070198_csr_exec_pkg.sv
// rtl/ysyx_25070198_csr_exec_pkg.sv - shared Zicsr encodings, FSM states and CSR addresses
// Purpose: constants shared by the CSR execution unit, its ALU and the testbench.
// Ports: none (package).
package ysyx_25070198_csr_exec_pkg;

   // Zicsr funct3 encodings (000 and 100 are not CSR ops)
   localparam logic [2:0] F3_RW  = 3'b001;
   localparam logic [2:0] F3_RS  = 3'b010;
   localparam logic [2:0] F3_RC  = 3'b011;
   localparam logic [2:0] F3_RWI = 3'b101;
   localparam logic [2:0] F3_RSI = 3'b110;
   localparam logic [2:0] F3_RCI = 3'b111;

   // Machine-level CSR addresses used by the unit and its environment
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/ysyx_25070198_csr_alu.sv
// rtl/ysyx_25070198_csr_alu.sv - combinational operand select and RW/RS/RC update
// Purpose: computes the new CSR value and whether a write is needed.
// Ports: funct3, rs1_val, rs1_idx (zimm), old_val in; new_val, write_req out.
module ysyx_25070198_csr_alu #(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [4:0]      rs1_idx,
   input  logic [XLEN-1:0] old_val,
   output logic [XLEN-1:0] new_val,
   output logic            write_req
);

   logic [XLEN-1:0] operand;

   // Immediate forms use rs1_idx as a zero-extended 5-bit immediate
   assign operand = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;

   always_comb begin
      new_val = old_val;
      case (funct3[1:0])
         2'b01:   new_val = operand;
         2'b10:   new_val = old_val | operand;
         2'b11:   new_val = old_val & ~operand;
         default: new_val = old_val;
      endcase
   end

   // Set/clear with x0 or zimm=0 are pure reads and must not touch the CSR
   assign write_req = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);

endmodule

// File: rtl/ysyx_25070198_csr_exec.sv
// rtl/ysyx_25070198_csr_exec.sv - Zicsr instruction execution unit (IDLE/READ/WRITE/RESP)
// Purpose: accepts one CSR instruction, reads the CSR, optionally writes it once,
//          then returns the old value with an illegal-instruction flag.
// Ports: clk, rst; req_* request handshake and operands; csr_addr/csr_wen/csr_wdata/
//        csr_rdata CSR file access; resp_* response handshake and result.
module ysyx_25070198_csr_exec
   import ysyx_25070198_csr_exec_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_csr,
   input  logic [XLEN-1:0]   req_rs1_val,
   input  logic [4:0]        req_rs1_idx,
   input  logic [4:0]        req_rd,
   output logic [ADDR_W-1:0] csr_addr,
   output logic              csr_wen,
   output logic [XLEN-1:0]   csr_wdata,
   input  logic [XLEN-1:0]   csr_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [4:0]        resp_rd,
   output logic              resp_rd_wen,
   output logic [XLEN-1:0]   resp_rd_data,
   output logic              resp_illegal
);

   state_t            state;
   logic              ready_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] csr_q;
   logic [XLEN-1:0]   rs1_val_q;
   logic [4:0]        rs1_idx_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   new_q;

   logic [XLEN-1:0]   new_val;
   logic              write_req;
   logic              illegal;
   logic              do_write;

   ysyx_25070198_csr_alu #(.XLEN(XLEN)) u_alu (
      .funct3    (funct3_q),
      .rs1_val   (rs1_val_q),
      .rs1_idx   (rs1_idx_q),
      .old_val   (csr_rdata),
      .new_val   (new_val),
      .write_req (write_req)
   );

   // The top two address bits equal to 11 mark the read-only CSR space
   assign illegal  = (funct3_q[1:0] == 2'b00) ||
                     (write_req && (csr_q[ADDR_W-1 -: 2] == 2'b11));
   assign do_write = write_req && !illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         ready_q      <= 1'b0;
         funct3_q     <= '0;
         csr_q        <= '0;
         rs1_val_q    <= '0;
         rs1_idx_q    <= '0;
         rd_q         <= '0;
         new_q        <= '0;
         resp_rd      <= '0;
         resp_rd_wen  <= 1'b0;
         resp_rd_data <= '0;
         resp_illegal <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // ready is registered so it stays low during reset and rises one edge later
               if (req_valid && ready_q) begin
                  funct3_q  <= req_funct3;
                  csr_q     <= req_csr;
                  rs1_val_q <= req_rs1_val;
                  rs1_idx_q <= req_rs1_idx;
                  rd_q      <= req_rd;
                  ready_q   <= 1'b0;
                  state     <= S_READ;
               end else begin
                  ready_q   <= 1'b1;
               end
            end
            S_READ: begin
               // Write data is frozen here; the CSR is not re-read in WRITE
               new_q        <= new_val;
               resp_rd      <= rd_q;
               resp_rd_wen  <= (rd_q != 5'd0) && !illegal;
               resp_rd_data <= csr_rdata;
               resp_illegal <= illegal;
               state        <= do_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
               state <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  ready_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: begin
               ready_q <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // Strobes decode directly from the state register so an asynchronous reset kills them at once
   assign req_ready  = ready_q;
   assign csr_addr   = (state == S_READ || state == S_WRITE) ? csr_q : '0;
   assign csr_wen    = (state == S_WRITE);
   assign csr_wdata  = (state == S_WRITE) ? new_q : '0;
   assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_ysyx_25070198_csr_exec.sv
// tb/tb_ysyx_25070198_csr_exec.sv - directed self-checking bench for ysyx_25070198_csr_exec
module tb_ysyx_25070198_csr_exec;
   import ysyx_25070198_csr_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [11:0] req_csr = '0;
   logic [31:0] req_rs1_val = '0;
   logic [4:0]  req_rs1_idx = '0;
   logic [4:0]  req_rd = '0;
   logic [11:0] csr_addr;
   logic        csr_wen;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [4:0]  resp_rd;
   logic        resp_rd_wen;
   logic [31:0] resp_rd_data;
   logic        resp_illegal;

   int errors = 0;
   int checks = 0;

   logic [31:0] mcycle  = 32'hDEAD0001;
   logic [31:0] mcycleh = 32'h000000FF;
   logic [31:0] marchid = 32'h00000019;
   int          wen_cnt = 0;
   logic [31:0] last_wdata = '0;
   logic [11:0] last_waddr = '0;

   always #5 clk = ~clk;

   ysyx_25070198_csr_exec #(.ADDR_W(12), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_csr      (req_csr),
      .req_rs1_val  (req_rs1_val),
      .req_rs1_idx  (req_rs1_idx),
      .req_rd       (req_rd),
      .csr_addr     (csr_addr),
      .csr_wen      (csr_wen),
      .csr_wdata    (csr_wdata),
      .csr_rdata    (csr_rdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rd      (resp_rd),
      .resp_rd_wen  (resp_rd_wen),
      .resp_rd_data (resp_rd_data),
      .resp_illegal (resp_illegal)
   );

   // CSR file model: combinational read, writes applied on the clock edge
   always_comb begin
      csr_rdata = 32'h0;
      case (csr_addr)
         CSR_MCYCLE:    csr_rdata = mcycle;
         CSR_MCYCLEH:   csr_rdata = mcycleh;
         CSR_MVENDORID: csr_rdata = 32'h79737978;
         CSR_MARCHID:   csr_rdata = marchid;
         default:       csr_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (csr_wen) begin
         wen_cnt    <= wen_cnt + 1;
         last_wdata <= csr_wdata;
         last_waddr <= csr_addr;
         if (csr_addr == CSR_MCYCLE)  mcycle  <= csr_wdata;
         if (csr_addr == CSR_MCYCLEH) mcycleh <= csr_wdata;
      end
   end

   task automatic do_req(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] v,
                         input logic [4:0] idx, input logic [4:0] rd, output int lat);
      int n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_timeout got=%b exp=1", req_ready); end
      req_funct3 = f3; req_csr = csr; req_rs1_val = v; req_rs1_idx = idx; req_rd = rd; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL rst_csr_wen got=%b exp=0", csr_wen); end
      checks++; if (csr_wdata !== 32'h0) begin errors++; $display("FAIL rst_csr_wdata got=%h exp=0", csr_wdata); end
      checks++; if (csr_addr !== 12'h0) begin errors++; $display("FAIL rst_csr_addr got=%h exp=0", csr_addr); end
      checks++; if ({resp_rd, resp_rd_wen, resp_illegal} !== 7'h0) begin errors++; $display("FAIL rst_resp_flags got=%h exp=0", {resp_rd, resp_rd_wen, resp_illegal}); end
      checks++; if (resp_rd_data !== 32'h0) begin errors++; $display("FAIL rst_resp_rd_data got=%h exp=0", resp_rd_data); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got=%b exp=0", req_ready); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_csrrw();
      int lat; int w0 = wen_cnt;
      do_req(F3_RW, CSR_MCYCLE, 32'h1234, 5'd1, 5'd5, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rw_latency got=%0d exp=3", lat); end
      checks++; if (wen_cnt - w0 !== 1) begin errors++; $display("FAIL rw_wen_count got=%0d exp=1", wen_cnt - w0); end
      checks++; if (last_wdata !== 32'h1234) begin errors++; $display("FAIL rw_wdata got=%h exp=1234", last_wdata); end
      checks++; if (last_waddr !== 12'hB00) begin errors++; $display("FAIL rw_waddr got=%h exp=b00", last_waddr); end
      checks++; if (resp_rd !== 5'd5) begin errors++; $display("FAIL rw_resp_rd got=%0d exp=5", resp_rd); end
      checks++; if (resp_rd_wen !== 1'b1) begin errors++; $display("FAIL rw_rd_wen got=%b exp=1", resp_rd_wen); end
      checks++; if (resp_rd_data !== 32'hDEAD0001) begin errors++; $display("FAIL rw_rd_data got=%h exp=dead0001", resp_rd_data); end
      checks++; if (resp_illegal !== 1'b0) begin errors++; $display("FAIL rw_illegal got=%b exp=0", resp_illegal); end
      release_resp();
   endtask

   task automatic test_csrrs_set();
      int lat; int w0 = wen_cnt;
      do_req(F3_RS, CSR_MCYCLE, 32'h0F0F0000, 5'd2, 5'd3, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rs_latency got=%0d exp=3", lat); end
      checks++; if (wen_cnt - w0 !== 1) begin errors++; $display("FAIL rs_wen_count got=%0d exp=1", wen_cnt - w0); end
      checks++; if (last_wdata !== 32'h0F0F1234) begin errors++; $display("FAIL rs_wdata got=%h exp=0f0f1234", last_wdata); end
      checks++; if (resp_rd_data !== 32'h1234) begin errors++; $display("FAIL rs_rd_data got=%h exp=1234", resp_rd_data); end
      release_resp();
   endtask

   task automatic test_read_only_read();
      int lat; int w0 = wen_cnt;
      do_req(F3_RS, CSR_MVENDORID, 32'hFFFF, 5'd0, 5'd7, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ro_read_latency got=%0d exp=2", lat); end
      checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL ro_read_wen got=%0d exp=0", wen_cnt - w0); end
      checks++; if (resp_rd_data !== 32'h79737978) begin errors++; $display("FAIL ro_read_data got=%h exp=79737978", resp_rd_data); end
      checks++; if (resp_illegal !== 1'b0) begin errors++; $display("FAIL ro_read_illegal got=%b exp=0", resp_illegal); end
      checks++; if (resp_rd_wen !== 1'b1) begin errors++; $display("FAIL ro_read_rd_wen got=%b exp=1", resp_rd_wen); end
      release_resp();
   endtask

   task automatic test_read_only_write();
      int lat; int w0 = wen_cnt;
      do_req(F3_RS, CSR_MARCHID, 32'h5, 5'd3, 5'd4, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ro_write_latency got=%0d exp=2", lat); end
      checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL ro_write_wen got=%0d exp=0", wen_cnt - w0); end
      checks++; if (resp_illegal !== 1'b1) begin errors++; $display("FAIL ro_write_illegal got=%b exp=1", resp_illegal); end
      checks++; if (resp_rd_wen !== 1'b0) begin errors++; $display("FAIL ro_write_rd_wen got=%b exp=0", resp_rd_wen); end
      checks++; if (resp_rd_data !== 32'h19) begin errors++; $display("FAIL ro_write_rd_data got=%h exp=19", resp_rd_data); end
      release_resp();
   endtask

   task automatic test_bad_funct3();
      int lat; int w0 = wen_cnt;
      do_req(3'b100, CSR_MCYCLE, 32'h1, 5'd1, 5'd6, lat);
      checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL f3_wen got=%0d exp=0", wen_cnt - w0); end
      checks++; if (resp_illegal !== 1'b1) begin errors++; $display("FAIL f3_illegal got=%b exp=1", resp_illegal); end
      checks++; if (resp_rd_wen !== 1'b0) begin errors++; $display("FAIL f3_rd_wen got=%b exp=0", resp_rd_wen); end
      release_resp();
   endtask

   task automatic test_csrrci();
      int lat; int w0 = wen_cnt;
      do_req(F3_RCI, CSR_MCYCLEH, 32'hFFFFFFFF, 5'h0F, 5'd0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rci_latency got=%0d exp=3", lat); end
      checks++; if (wen_cnt - w0 !== 1) begin errors++; $display("FAIL rci_wen_count got=%0d exp=1", wen_cnt - w0); end
      checks++; if (last_wdata !== 32'hF0) begin errors++; $display("FAIL rci_wdata got=%h exp=f0", last_wdata); end
      checks++; if (resp_rd_data !== 32'hFF) begin errors++; $display("FAIL rci_rd_data got=%h exp=ff", resp_rd_data); end
      checks++; if (resp_rd_wen !== 1'b0) begin errors++; $display("FAIL rci_rd_wen_x0 got=%b exp=0", resp_rd_wen); end
      release_resp();
   endtask

   task automatic test_backpressure();
      int lat;
      do_req(F3_RSI, CSR_MCYCLEH, 32'h0, 5'd1, 5'd9, lat);
      for (int i = 0; i < 5; i++) begin
         checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, resp_valid); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
         checks++; if (resp_rd_data !== 32'hF0 || resp_rd !== 5'd9 || resp_rd_wen !== 1'b1 || resp_illegal !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b/%b exp=f0/9/1/0", i, resp_rd_data, resp_rd, resp_rd_wen, resp_illegal);
         end
         @(negedge clk);
      end
      checks++; if (last_wdata !== 32'hF1) begin errors++; $display("FAIL bp_wdata got=%h exp=f1", last_wdata); end
      release_resp();
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=1/0", req_ready, resp_valid); end
   endtask

   task automatic test_reset_in_read();
      int lat; int w0 = wen_cnt;
      int n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_funct3 = F3_RW; req_csr = CSR_MCYCLE; req_rs1_val = 32'hAAAA; req_rs1_idx = 5'd1; req_rd = 5'd2; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (csr_addr !== 12'hB00) begin errors++; $display("FAIL rr_in_read_addr got=%h exp=b00", csr_addr); end
      rst = 1'b1;
      #1;
      checks++; if (csr_wen !== 1'b0 || csr_addr !== 12'h0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL rr_async got=%b/%h/%b/%b exp=0/0/0/0", csr_wen, csr_addr, req_ready, resp_valid);
      end
      checks++; if (resp_rd_data !== 32'h0 || resp_rd !== 5'd0 || resp_illegal !== 1'b0) begin
         errors++; $display("FAIL rr_resp_reset got=%h/%0d/%b exp=0/0/0", resp_rd_data, resp_rd, resp_illegal);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (wen_cnt - w0 !== 0) begin errors++; $display("FAIL rr_no_wen got=%0d exp=0", wen_cnt - w0); end
      do_req(F3_RW, CSR_MCYCLE, 32'h55, 5'd1, 5'd1, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rr_next_latency got=%0d exp=3", lat); end
      checks++; if (wen_cnt - w0 !== 1 || last_wdata !== 32'h55) begin errors++; $display("FAIL rr_next_write got=%0d/%h exp=1/55", wen_cnt - w0, last_wdata); end
      checks++; if (resp_rd_data !== 32'h0F0F1234) begin errors++; $display("FAIL rr_next_rd_data got=%h exp=0f0f1234", resp_rd_data); end
      release_resp();
   endtask

   initial begin
      test_reset();
      test_csrrw();
      test_csrrs_set();
      test_read_only_read();
      test_read_only_write();
      test_bad_funct3();
      test_csrrci();
      test_backpressure();
      test_reset_in_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25070198_csr_exec.md
YSYX_25070198_CSR_EXEC -- requirements
Module: ysyx_25070198_csr_exec

Interface
REQ-001: Parameter ADDR_W, default 12, CSR address width.
REQ-002: Parameter XLEN, default 32, data width.
REQ-003: Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  CSR instruction offered.
- req_ready  output  1  unit can accept a request.
- req_funct3  input  3  Zicsr op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_csr  input  ADDR_W  target CSR address.
- req_rs1_val  input  XLEN  rs1 register value.
- req_rs1_idx  input  5  rs1 index; doubles as zimm for the immediate forms.
- req_rd  input  5  destination register index.
- csr_addr  output  ADDR_W  address to the CSR file.
- csr_wen  output  1  CSR write strobe, one cycle.
- csr_wdata  output  XLEN  CSR write data.
- csr_rdata  input  XLEN  combinational read data for csr_addr.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_rd  output  5  destination index.
- resp_rd_wen  output  1  register write enable (0 when rd=x0 or illegal).
- resp_rd_data  output  XLEN  old CSR value.
- resp_illegal  output  1  illegal-instruction flag.

Function
REQ-004: FSM states are IDLE, READ, WRITE and RESP; req_ready=1 only in IDLE.
REQ-005: In IDLE, on req_valid, the unit latches funct3, csr, rs1_val, rs1_idx and rd, then goes to READ.
REQ-006: In READ, csr_addr = latched csr; the unit captures csr_rdata into old_val and computes new_val; go to WRITE if a write is required, else RESP.
REQ-007: Operand = rs1_val for funct3[2]=0; zero-extended rs1_idx for funct3[2]=1.
REQ-008: new_val by funct3[1:0]: RW = operand; RS = old_val | operand; RC = old_val & ~operand.
REQ-009: A write is required for RW/RWI always; for RS/RC/RSI/RCI only when rs1_idx != 0.
REQ-010: In WRITE, csr_wen=1 for exactly one cycle with csr_addr=latched csr and csr_wdata=new_val; then go to RESP.
REQ-011: csr_wen SHALL be 0 in every state except WRITE.
REQ-012: Write data is the value computed in READ, not re-read; a free-running counter CSR therefore loses its increments between READ and WRITE (accepted behaviour).
REQ-013: Illegal if funct3 is 000 or 100, or if a write is required and csr[11:10]==2'b11 (read-only space).
REQ-014: An illegal request never asserts csr_wen, goes READ -> RESP, and reports resp_illegal=1 with resp_rd_wen=0.
REQ-015: In RESP, resp_valid=1 and outputs hold stable until resp_ready; on resp_ready go to IDLE.
REQ-016: resp_rd_data = old_val; resp_rd_wen = (rd != 0) and not illegal.
REQ-017: Minimum latency req accept to resp_valid is 2 cycles without a write and 3 with a write; throughput is at most one request per 3-4 cycles.
REQ-018: csr_addr = latched csr in READ/WRITE and 0 otherwise.

Reset
REQ-019: Asserting rst at any time forces IDLE asynchronously; a pending write is dropped and no csr_wen is issued.
REQ-020: Under reset: req_ready=0, resp_valid=0, csr_wen=0, csr_wdata=0, csr_addr=0, resp_rd=0, resp_rd_wen=0, resp_rd_data=0, resp_illegal=0.
REQ-021: req_ready rises the first cycle after rst deasserts.

Structure
REQ-022: funct3 encodings, FSM state encodings and CSR addresses (B00 mcycle, B80 mcycleh, F11 mvendorid, F12 marchid) SHALL live in a shared package.
REQ-023: One sub-module ysyx_25070198_csr_alu (pure combinational operand select and RW/RS/RC logic) is natural; the FSM stays in the top.

Verification
REQ-024: CSRRW csr=B00, rs1_val=0x1234, rd=5 -> one csr_wen with wdata 0x1234; resp_rd=5, rd_wen=1, rd_data = prior mcycle.
REQ-025: CSRRS csr=F11, rs1_idx=0 -> no csr_wen, resp_rd_data=0x79737978, illegal=0.
REQ-026: CSRRS csr=F12, rs1_idx=3 -> no csr_wen, resp_illegal=1, rd_wen=0.
REQ-027: CSRRCI csr=B80 with mcycleh=0xFF, zimm=0x0F -> csr_wdata=0xF0.
REQ-028: Hold resp_ready=0 for 5 cycles -> resp outputs stable and req_ready=0 throughout.
REQ-029: Assert rst in the READ cycle of a CSRRW -> no csr_wen ever, outputs at reset values, next request handled normally.
